ad7124_read_scheduler: RTL and testbench

Sequences register reads of one AD7124-8 over a shared single-transaction SPI engine. Polls STATUS (0x40) until RDY asserts, then reads DATA (0x42) and tags each 24-bit result with the active channel from the status byte. Tracks which enabled channels have been captured and pulses a frame-complete strobe when every enabled channel has one fresh sample. Sits between the thermocouple capture logic and the SPI master, replacing free-running delay-counter sequencing with a handshake-driven scheduler.

---
 rtl/ad7124_read_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_ad7124_read_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7124_read_scheduler.sv
// AD7124-8 STATUS-poll / DATA-read scheduler over a single-transaction SPI command/response engine.
// Optional poll timeout: define AD7124_SCHED_TIMEOUT_EN.
module ad7124_read_scheduler #(
  parameter int unsigned GAP_CYCLES = 900,
  parameter int unsigned MAX_POLLS  = 255,
  parameter int unsigned NUM_CH     = 8
) (
  input  logic        PL_clk,
  input  logic        PL_USER_RST_N,
  input  logic        start,
  input  logic [15:0] ch_mask,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_byte,
  output logic [1:0]  cmd_nbytes,
  input  logic        resp_valid,
  input  logic [23:0] resp_data,
  output logic        result_valid,
  output logic [3:0]  result_ch,
  output logic [23:0] result_data,
  output logic        frame_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);
  localparam logic [15:0] CH_VALID   = 16'((33'd1 << NUM_CH) - 33'd1);
  localparam logic [7:0]  CMD_STATUS = 8'h40;
  localparam logic [7:0]  CMD_DATA   = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_REQ, S_POLL_WAIT, S_READ_REQ, S_READ_WAIT, S_GAP
  } state_t;

  state_t          r_state;
  logic [15:0]     r_mask;
  logic [15:0]     r_seen;
  logic [3:0]      r_ch;
  logic [GW-1:0]   r_gap_cnt;
  logic [PW-1:0]   r_poll_cnt;

  logic [15:0]     w_mask_in;
  logic [15:0]     w_seen_nxt;
  logic            w_ch_ok;
  logic [PW-1:0]   w_poll_nxt;
  logic            w_poll_limit;

  assign w_mask_in  = ch_mask & CH_VALID;
  assign w_seen_nxt = r_seen | (16'd1 << r_ch);
  assign w_ch_ok    = ({1'b0, r_ch} < 5'(NUM_CH)) && r_mask[r_ch];
  assign w_poll_nxt = r_poll_cnt + PW'(1);

  // Main scheduler: every command and result field is registered here.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_seen       <= '0;
      r_ch         <= '0;
      r_gap_cnt    <= '0;
      r_poll_cnt   <= '0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'h00;
      cmd_nbytes   <= 2'd0;
      result_valid <= 1'b0;
      result_ch    <= 4'h0;
      result_data  <= 24'h0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (w_mask_in != 16'h0)) begin
            r_mask     <= w_mask_in;
            r_seen     <= '0;
            r_poll_cnt <= '0;
            cmd_valid  <= 1'b1;
            cmd_byte   <= CMD_STATUS;
            cmd_nbytes <= 2'd1;
            busy       <= 1'b1;
            r_state    <= S_POLL_REQ;
          end
        end
        // An accepted command is already in flight, so the handshake wins over a falling start.
        S_POLL_REQ, S_READ_REQ: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_state   <= (r_state == S_POLL_REQ) ? S_POLL_WAIT : S_READ_WAIT;
          end else if (!start) begin
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_POLL_WAIT: begin
          if (resp_valid) begin
            if (!start) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else if (!resp_data[7]) begin
              r_ch       <= resp_data[3:0];
              cmd_valid  <= 1'b1;
              cmd_byte   <= CMD_DATA;
              cmd_nbytes <= 2'd3;
              r_state    <= S_READ_REQ;
            end else begin
              r_poll_cnt <= w_poll_limit ? '0 : w_poll_nxt;
              r_gap_cnt  <= '0;
              r_state    <= S_GAP;
            end
          end
        end
        S_READ_WAIT: begin
          if (resp_valid) begin
            r_poll_cnt <= '0;
            if (!start) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              if (w_ch_ok) begin
                result_valid <= 1'b1;
                result_ch    <= r_ch;
                result_data  <= resp_data;
                if (w_seen_nxt == r_mask) begin
                  frame_done <= 1'b1;
                  r_seen     <= '0;
                end else begin
                  r_seen <= w_seen_nxt;
                end
              end
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            if (start) begin
              cmd_valid  <= 1'b1;
              cmd_byte   <= CMD_STATUS;
              cmd_nbytes <= 2'd1;
              r_state    <= S_POLL_REQ;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AD7124_SCHED_TIMEOUT_EN
  assign w_poll_limit = (w_poll_nxt == PW'(MAX_POLLS));

  // Sticky timeout flag; cleared only when a new session is requested from IDLE.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      timeout_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      timeout_err <= 1'b0;
    end else if ((r_state == S_POLL_WAIT) && resp_valid && start && resp_data[7] && w_poll_limit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign w_poll_limit = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ad7124_read_scheduler.sv
// Bench for ad7124_read_scheduler: behavioural SPI engine driven from a vector table, results checked
// through a scoreboard queue. Timeout expectations follow AD7124_SCHED_TIMEOUT_EN.
module tb_ad7124_read_scheduler;

  localparam int unsigned GAP  = 4;
  localparam int unsigned MAXP = 3;
  localparam int unsigned NCH  = 8;
`ifdef AD7124_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ch_mask = 16'h0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_byte;
  logic [1:0]  cmd_nbytes;
  logic        resp_valid = 1'b0;
  logic [23:0] resp_data = 24'h0;
  logic        result_valid;
  logic [3:0]  result_ch;
  logic [23:0] result_data;
  logic        frame_done;
  logic        busy;
  logic        timeout_err;

  ad7124_read_scheduler #(.GAP_CYCLES(GAP), .MAX_POLLS(MAXP), .NUM_CH(NCH)) dut (
    .PL_clk(clk), .PL_USER_RST_N(rst_n), .start(start), .ch_mask(ch_mask),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte), .cmd_nbytes(cmd_nbytes),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  status;
    logic [23:0] data;
    bit          exp_read;
    bit          exp_res;
    logic [3:0]  exp_ch;
    bit          exp_fd;
  } vec_t;

  typedef struct {
    logic [3:0]  ch;
    logic [23:0] data;
    bit          fd;
  } sb_t;

  vec_t vecs[11];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n40 = 0;
  int   n42 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] all_outs();
    return {cmd_valid, cmd_byte, cmd_nbytes, result_valid, result_ch, result_data,
            frame_done, busy, timeout_err};
  endfunction

  // Command counter and result scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (cmd_byte == 8'h40) n40++;
      if (cmd_byte == 8'h42) n42++;
    end
    if (result_valid) begin
      sb_t e;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got ch %0d data 0x%0h, none expected", result_ch, result_data);
      end else begin
        e = sbq.pop_front();
        check("result", {35'h0, result_ch, result_data, frame_done}, {35'h0, e.ch, e.data, e.fd});
      end
    end else if (frame_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL lone_frame_done: got 1 without result_valid, expected 0");
    end
  end

  task automatic wait_cmd(output int cyc);
    cyc = 0;
    while (!cmd_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!cmd_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_wait: got no cmd_valid in %0d cycles, expected one", cyc);
    end
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic respond(input logic [23:0] d);
    @(posedge clk); #1;
    resp_valid = 1'b1;
    resp_data  = d;
    @(posedge clk); #1;
    resp_valid = 1'b0;
  endtask

  task automatic serve_row(input vec_t v, input int exp_lat);
    int cyc;
    wait_cmd(cyc);
    check("poll_latency", 64'(cyc), 64'(exp_lat));
    check("poll_cmd", {54'h0, cmd_byte, cmd_nbytes}, {54'h0, 8'h40, 2'd1});
    handshake();
    respond({16'h0, v.status});
    if (v.exp_read) begin
      wait_cmd(cyc);
      check("read_latency", 64'(cyc), 64'd0);
      check("read_cmd", {54'h0, cmd_byte, cmd_nbytes}, {54'h0, 8'h42, 2'd3});
      handshake();
      if (v.exp_res) sbq.push_back('{v.exp_ch, v.data, v.exp_fd});
      respond(v.data);
    end
  endtask

  task automatic stop_session();
    int  cyc;
    bit  saw_cmd;
    start   = 1'b0;
    cyc     = 0;
    saw_cmd = 1'b0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1;
      if (cmd_valid) saw_cmd = 1'b1;
      cyc++;
    end
    check("stop_idle_busy", 64'(busy), 64'd0);
    check("stop_no_cmd", 64'(saw_cmd), 64'd0);
  endtask

  task automatic run_case(input logic [15:0] mask, input int lo, input int hi);
    ch_mask = mask;
    start   = 1'b1;
    @(posedge clk); #1;
    ch_mask = 16'hFFFF;
    check("start_latency", 64'(cmd_valid), 64'd1);
    for (int i = lo; i <= hi; i++) serve_row(vecs[i], (i == lo) ? 0 : int'(GAP));
    stop_session();
    check("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected bench end");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  flag;
    //          status  data        rd    res   ch    fd
    vecs[0]  = '{8'h80, 24'h000000, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{8'h80, 24'h000000, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{8'h00, 24'h123456, 1'b1, 1'b1, 4'd0, 1'b1};
    vecs[3]  = '{8'h00, 24'h0A0A0A, 1'b1, 1'b1, 4'd0, 1'b0};
    vecs[4]  = '{8'h02, 24'h0B0B0B, 1'b1, 1'b1, 4'd2, 1'b1};
    vecs[5]  = '{8'h02, 24'h0C0C0C, 1'b1, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{8'h0C, 24'hABCDEF, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{8'h05, 24'h555555, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{8'h0F, 24'hFFFFFF, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[9]  = '{8'h41, 24'h111111, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[10] = '{8'h00, 24'h000000, 1'b1, 1'b1, 4'd0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 64'(all_outs()), 64'd0);

    // Single channel: two not-ready polls then a sample.
    n40 = 0; n42 = 0;
    run_case(16'h0001, 0, 2);
    check("caseA_polls", 64'(n40), 64'd3);
    check("caseA_reads", 64'(n42), 64'd1);

    // Two channels with a duplicate after frame completion.
    run_case(16'h0005, 3, 5);

    // Out-of-range, unmasked and in-range channels.
    run_case(16'h0003, 6, 10);

    // start dropped while the data read is outstanding.
    ch_mask = 16'h0001;
    start   = 1'b1;
    @(posedge clk); #1;
    wait_cmd(cyc);
    handshake();
    respond(24'h000000);
    wait_cmd(cyc);
    handshake();
    start = 1'b0;
    respond(24'h777777);
    check("drop_wait_busy", 64'(busy), 64'd0);
    flag = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cmd_valid || busy) flag = 1'b1;
    end
    check("drop_wait_quiet", 64'(flag), 64'd0);

    // start dropped before a pending command is accepted.
    start = 1'b1;
    @(posedge clk); #1;
    check("drop_req_valid", 64'(cmd_valid), 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_req_idle", {62'h0, cmd_valid, busy}, 64'd0);

    // Continuous not-ready polling with optional timeout.
    ch_mask = 16'h0001;
    start   = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      serve_row(vecs[0], (i == 0) ? 0 : int'(GAP));
      check("timeout_err", 64'(timeout_err), 64'(TO_EN && (i >= 2)));
    end
    wait_cmd(cyc);
    check("poll_continues", 64'(cyc), 64'(GAP));
    start = 1'b0;
    @(posedge clk); #1;
    check("timeout_sticky_idle", {62'h0, busy, timeout_err}, {62'h0, 1'b0, TO_EN});
    start = 1'b1;
    @(posedge clk); #1;
    check("timeout_cleared", 64'(timeout_err), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;

    // Back-pressured poll command, then asynchronous reset mid-wait.
    ch_mask = 16'h0001;
    start   = 1'b1;
    @(posedge clk); #1;
    flag = 1'b1;
    repeat (10) begin
      if (!(cmd_valid && cmd_byte == 8'h40 && cmd_nbytes == 2'd1)) flag = 1'b0;
      @(posedge clk); #1;
    end
    check("req_stable", 64'(flag), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'(all_outs()), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(all_outs()), 64'd0);
    check("sb_final", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
